// File: rtl/toggle_monitor_if.sv
// Signal bundle between a toggle source/consumer and the toggle_monitor.
// The master drives the monitored waveform and controls; the slave is the monitor.
interface toggle_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             din;
  logic             clr;
  logic             locked;
  logic             stuck;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output en, din, clr,
    input  locked, stuck, err_pulse, err_cnt, edge_cnt
  );

  modport slave (
    input  en, din, clr,
    output locked, stuck, err_pulse, err_cnt, edge_cnt
  );
endinterface

// File: rtl/toggle_monitor.sv
// Liveness/period monitor for a free-running toggle waveform: measures edge
// intervals, declares lock after a run of good intervals, flags period errors and stuck-at.
module toggle_monitor #(
  parameter int HALF_PERIOD = 2,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  toggle_monitor_if.slave mon
);

  localparam int STUCK_TH = 2 * HALF_PERIOD + TOL;
  localparam int RUN_MAX  = STUCK_TH + 1;
  localparam int RUN_W    = $clog2(RUN_MAX + 1);
  localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX_V  = RUN_W'(RUN_MAX);
  localparam logic [RUN_W-1:0]  STUCK_TH_V = RUN_W'(STUCK_TH);
  localparam logic [RUN_W:0]    IV_MIN     = (RUN_W+1)'(HALF_PERIOD - TOL);
  localparam logic [RUN_W:0]    IV_MAX     = (RUN_W+1)'(HALF_PERIOD + TOL);
  localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL  = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_e;

  state_e            state_q, state_d;
  logic              din_q, din_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic              stuck_q, stuck_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;

  logic             edge_det;
  logic             good_iv;
  logic             stuck_hit;
  logic             err_set;
  logic             stuck_set;
  logic [RUN_W:0]   interval;

  assign edge_det  = mon.en & (mon.din ^ din_q);
  assign interval  = {1'b0, run_cnt_q} + (RUN_W+1)'(1);
  assign good_iv   = (interval >= IV_MIN) && (interval <= IV_MAX);
  assign stuck_hit = (run_cnt_q >= STUCK_TH_V);

  // An edge always wins over the stuck threshold, so it is tested first.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_set    = 1'b0;
    stuck_set  = 1'b0;
    din_d      = mon.din;

    if (!mon.en || state_q == IDLE || edge_det) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RUN_MAX_V) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end else begin
      run_cnt_d = run_cnt_q;
    end

    if (!mon.en) begin
      state_d    = IDLE;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
        ACQUIRE: begin
          if (edge_det) begin
            state_d    = TRACK;
            good_cnt_d = '0;
          end
        end
        TRACK: begin
          if (edge_det) begin
            if (!good_iv) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == GOOD_LAST) begin
              good_cnt_d = GOOD_FULL;
              state_d    = LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else if (stuck_hit) begin
            stuck_set  = 1'b1;
            good_cnt_d = '0;
            state_d    = ACQUIRE;
          end
        end
        LOCKED: begin
          if (edge_det) begin
            if (!good_iv) begin
              err_set    = 1'b1;
              good_cnt_d = '0;
              state_d    = TRACK;
            end
          end else if (stuck_hit) begin
            stuck_set  = 1'b1;
            err_set    = 1'b1;
            good_cnt_d = '0;
            state_d    = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A clear in the same cycle as a new error leaves exactly that error counted.
    if (mon.clr) begin
      err_cnt_d = CNT_W'(err_set);
    end else if (err_set && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end

    if (mon.clr) begin
      edge_cnt_d = '0;
    end else if (edge_det) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q;
    end

    stuck_d     = mon.clr ? 1'b0 : (stuck_q | stuck_set);
    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      din_q       <= 1'b0;
      run_cnt_q   <= '0;
      good_cnt_q  <= '0;
      stuck_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      edge_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      run_cnt_q   <= run_cnt_d;
      good_cnt_q  <= good_cnt_d;
      stuck_q     <= stuck_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
    end
  end

  assign mon.locked    = locked_q;
  assign mon.stuck     = stuck_q;
  assign mon.err_pulse = err_pulse_q;
  assign mon.err_cnt   = err_cnt_q;
  assign mon.edge_cnt  = edge_cnt_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Bench for toggle_monitor: three parameterisations share one stimulus stream and are
// compared against a timestamp-based reference model plus directed constant checks.
module tb_toggle_monitor;

  localparam int N = 3;
  localparam int HP  [N] = '{2, 4, 2};
  localparam int TL  [N] = '{0, 1, 0};
  localparam int LC  [N] = '{4, 4, 4};
  localparam int CW  [N] = '{8, 8, 2};

  localparam int S_IDLE = 0, S_ACQ = 1, S_TRACK = 2, S_LOCKED = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;
  logic din   = 1'b0;
  logic clr   = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toggle_monitor_if #(.CNT_W(8)) if0 ();
  toggle_monitor_if #(.CNT_W(8)) if1 ();
  toggle_monitor_if #(.CNT_W(2)) if2 ();

  assign if0.en = en;  assign if0.din = din;  assign if0.clr = clr;
  assign if1.en = en;  assign if1.din = din;  assign if1.clr = clr;
  assign if2.en = en;  assign if2.din = din;  assign if2.clr = clr;

  toggle_monitor #(.HALF_PERIOD(2), .TOL(0), .LOCK_COUNT(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mon(if0));
  toggle_monitor #(.HALF_PERIOD(4), .TOL(1), .LOCK_COUNT(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mon(if1));
  toggle_monitor #(.HALF_PERIOD(2), .TOL(0), .LOCK_COUNT(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mon(if2));

  // Packed status {locked, stuck, err_pulse, err_cnt[7:0], edge_cnt[7:0]} per DUT.
  logic [18:0] obs [N];
  always_comb begin
    obs[0] = {if0.locked, if0.stuck, if0.err_pulse, if0.err_cnt, if0.edge_cnt};
    obs[1] = {if1.locked, if1.stuck, if1.err_pulse, if1.err_cnt, if1.edge_cnt};
    obs[2] = {if2.locked, if2.stuck, if2.err_pulse, 6'b0, if2.err_cnt, 6'b0, if2.edge_cnt};
  end

  // Reference model: intervals are differences of edge timestamps.
  int cyc;
  int m_state [N];
  int m_last  [N];
  int m_good  [N];
  int m_err   [N];
  int m_edges [N];
  bit m_prev  [N];
  bit m_stuck [N];
  bit m_lock  [N];
  bit m_pulse [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = S_IDLE; m_last[i] = 0; m_good[i] = 0; m_err[i] = 0; m_edges[i] = 0;
      m_prev[i] = 1'b0; m_stuck[i] = 1'b0; m_lock[i] = 1'b0; m_pulse[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < N; i++) begin
      bit e, er, ss, ok;
      int iv, maxv;
      e  = en && (din != m_prev[i]);
      m_prev[i] = din;
      er = 1'b0;
      ss = 1'b0;
      if (!en) begin
        m_state[i] = S_IDLE;
        m_good[i]  = 0;
      end else if (m_state[i] == S_IDLE) begin
        m_state[i] = S_ACQ;
        m_good[i]  = 0;
      end else if (m_state[i] == S_ACQ) begin
        if (e) begin
          m_state[i] = S_TRACK;
          m_last[i]  = cyc;
          m_good[i]  = 0;
        end
      end else if (e) begin
        iv = cyc - m_last[i];
        m_last[i] = cyc;
        ok = (iv >= HP[i] - TL[i]) && (iv <= HP[i] + TL[i]);
        if (m_state[i] == S_TRACK) begin
          if (ok) begin
            m_good[i]++;
            if (m_good[i] == LC[i]) m_state[i] = S_LOCKED;
          end else begin
            m_good[i] = 0;
          end
        end else if (!ok) begin
          er = 1'b1;
          m_good[i]  = 0;
          m_state[i] = S_TRACK;
        end
      end else if (cyc - m_last[i] == 2 * HP[i] + TL[i] + 1) begin
        ss = 1'b1;
        er = (m_state[i] == S_LOCKED);
        m_state[i] = S_ACQ;
        m_good[i]  = 0;
      end
      maxv = (1 << CW[i]) - 1;
      if (clr) m_edges[i] = 0;
      else if (e) m_edges[i] = (m_edges[i] + 1) % (1 << CW[i]);
      if (clr) m_err[i] = er ? 1 : 0;
      else if (er && m_err[i] < maxv) m_err[i] = m_err[i] + 1;
      m_stuck[i] = clr ? 1'b0 : (m_stuck[i] | ss);
      m_lock[i]  = (m_state[i] == S_LOCKED);
      m_pulse[i] = er;
    end
  endtask

  function automatic logic [18:0] exp_stat(int i);
    logic [7:0] ec, gc;
    ec = 8'(m_err[i]);
    gc = 8'(m_edges[i]);
    return {m_lock[i], m_stuck[i], m_pulse[i], ec, gc};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic toggle();
    din = ~din;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs[i] !== 19'd0) begin
        errors++;
        $display("[TB] FAIL reset_async_dut%0d got %h want 0", i, obs[i]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs[i] !== 19'd0) begin
        errors++;
        $display("[TB] FAIL reset_release_dut%0d got %h want 0", i, obs[i]);
      end
    end
  endtask

  task automatic test_lock();
    en = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      toggle();
      tick();
      checks += 3;
      if (if0.locked !== ((k == 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL lock_edge%0d locked got %0b want %0b", k, if0.locked, k == 5);
      end
      if (if0.edge_cnt !== 8'(k)) begin
        errors++;
        $display("[TB] FAIL lock_edge%0d edge_cnt got %0d want %0d", k, if0.edge_cnt, k);
      end
      if (if0.err_cnt !== 8'd0) begin
        errors++;
        $display("[TB] FAIL lock_edge%0d err_cnt got %0d want 0", k, if0.err_cnt);
      end
      tick();
    end
  endtask

  task automatic test_violation();
    tick();
    toggle();
    tick();
    checks += 3;
    if (if0.err_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL viol_pulse got %0b want 1", if0.err_pulse);
    end
    if (if0.err_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL viol_err_cnt got %0d want 1", if0.err_cnt);
    end
    if (if0.locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL viol_unlock got %0b want 0", if0.locked);
    end
    tick();
    checks++;
    if (if0.err_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL viol_pulse_width got %0b want 0", if0.err_pulse);
    end
    for (int j = 1; j <= 4; j++) begin
      toggle();
      tick();
      checks++;
      if (if0.locked !== ((j == 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL relock_good%0d locked got %0b want %0b", j, if0.locked, j == 4);
      end
      tick();
    end
  endtask

  task automatic test_stuck();
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++;
      if (if0.stuck !== 1'b0 || if0.locked !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stuck_early_c%0d stuck/locked got %0b%0b want 01", c, if0.stuck, if0.locked);
      end
    end
    tick();
    checks++;
    if ({if0.stuck, if0.err_pulse, if0.locked, if0.err_cnt} !== {3'b110, 8'd2}) begin
      errors++;
      $display("[TB] FAIL stuck_fire stuck/pulse/locked/err got %0b%0b%0b/%0d want 110/2",
               if0.stuck, if0.err_pulse, if0.locked, if0.err_cnt);
    end
    for (int c = 6; c <= 9; c++) begin
      tick();
      checks++;
      if (if0.err_pulse !== 1'b0 || if0.err_cnt !== 8'd2) begin
        errors++;
        $display("[TB] FAIL stuck_once_c%0d pulse/err got %0b/%0d want 0/2", c, if0.err_pulse, if0.err_cnt);
      end
    end
    for (int k = 1; k <= 5; k++) begin
      toggle();
      tick();
      checks++;
      if (if0.locked !== ((k == 5) ? 1'b1 : 1'b0) || if0.stuck !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stuck_relock%0d locked/stuck got %0b/%0b want %0b/1", k, if0.locked, if0.stuck, k == 5);
      end
      tick();
    end
  endtask

  task automatic test_tolerance();
    int ivs [4] = '{3, 5, 4, 5};
    en  = 1'b0;
    clr = 1'b1;
    tick();
    en  = 1'b1;
    clr = 1'b0;
    tick();
    checks++;
    if (obs[1] !== 19'd0) begin
      errors++;
      $display("[TB] FAIL tol_cleared got %h want 0", obs[1]);
    end
    toggle();
    tick();
    for (int idx = 0; idx < 4; idx++) begin
      repeat (ivs[idx] - 1) tick();
      toggle();
      tick();
      checks++;
      if (if1.locked !== ((idx == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL tol_iv%0d locked got %0b want %0b", ivs[idx], if1.locked, idx == 3);
      end
    end
    repeat (5) tick();
    toggle();
    tick();
    checks++;
    if ({if1.err_pulse, if1.locked, if1.err_cnt, if1.edge_cnt} !== {2'b10, 8'd1, 8'd6}) begin
      errors++;
      $display("[TB] FAIL tol_iv6 pulse/locked/err/edges got %0b%0b/%0d/%0d want 10/1/6",
               if1.err_pulse, if1.locked, if1.err_cnt, if1.edge_cnt);
    end
  endtask

  task automatic test_saturation();
    en  = 1'b0;
    clr = 1'b1;
    tick();
    en  = 1'b1;
    clr = 1'b0;
    tick();
    toggle(); tick(); tick();
    repeat (4) begin toggle(); tick(); tick(); end
    for (int e = 1; e <= 5; e++) begin
      tick();
      toggle();
      tick();
      checks++;
      if (if2.err_cnt !== 2'((e > 3) ? 3 : e) || if2.err_pulse !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sat_err%0d err/pulse got %0d/%0b want %0d/1", e, if2.err_cnt, if2.err_pulse, (e > 3) ? 3 : e);
      end
      tick();
      repeat (4) begin toggle(); tick(); tick(); end
    end
    checks++;
    if (if0.err_cnt !== 8'd5) begin
      errors++;
      $display("[TB] FAIL sat_wide_err got %0d want 5", if0.err_cnt);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if ({if2.err_cnt, if2.stuck, if2.edge_cnt} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL sat_clr err/stuck/edges got %0d/%0b/%0d want 0/0/0", if2.err_cnt, if2.stuck, if2.edge_cnt);
    end
    en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      toggle();
      tick();
      checks++;
      if (if2.edge_cnt !== 2'd0 || if2.locked !== 1'b0) begin
        errors++;
        $display("[TB] FAIL en_off_c%0d edges/locked got %0d/%0b want 0/0", c, if2.edge_cnt, if2.locked);
      end
    end
  endtask

  task automatic test_clr_collision();
    en = 1'b1;
    tick();
    toggle(); tick(); tick();
    repeat (4) begin toggle(); tick(); tick(); end
    checks++;
    if (if0.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coll_lock got %0b want 1", if0.locked);
    end
    tick();
    toggle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if ({if0.err_cnt, if0.err_pulse, if0.edge_cnt, if0.stuck} !== {8'd1, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL coll_clr err/pulse/edges/stuck got %0d/%0b/%0d/%0b want 1/1/0/0",
               if0.err_cnt, if0.err_pulse, if0.edge_cnt, if0.stuck);
    end
  endtask

  task automatic test_random();
    int hold   = 2;
    int en_off = 0;
    logic [18:0] exp;
    for (int c = 0; c < 3000; c++) begin
      if (hold <= 1) begin
        toggle();
        if ($urandom_range(0, 9) < 7) hold = ((c / 500) % 2 == 1) ? int'($urandom_range(3, 5)) : 2;
        else hold = int'($urandom_range(1, 12));
      end else begin
        hold--;
      end
      if (en_off == 0 && $urandom_range(0, 299) == 0) en_off = int'($urandom_range(1, 8));
      en = (en_off == 0);
      if (en_off > 0) en_off--;
      clr = ($urandom_range(0, 199) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        exp = exp_stat(i);
        checks++;
        if (obs[i] !== exp) begin
          errors++;
          $display("[TB] FAIL rand_dut%0d cyc %0d status got %h want %h", i, c, obs[i], exp);
        end
      end
    end
    clr = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_async_reset();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    repeat (5) begin toggle(); tick(); tick(); end
    checks++;
    if (if0.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_prelock got %0b want 1", if0.locked);
    end
    toggle();
    tick();
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs[i] !== 19'd0) begin
        errors++;
        $display("[TB] FAIL arst_dut%0d got %h want 0", i, obs[i]);
      end
    end
    model_reset();
    din = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      toggle();
      tick();
      checks++;
      if (if0.locked !== ((k == 5) ? 1'b1 : 1'b0) || if0.edge_cnt !== 8'(k)) begin
        errors++;
        $display("[TB] FAIL arst_relock%0d locked/edges got %0b/%0d want %0b/%0d", k, if0.locked, if0.edge_cnt, k == 5, k);
      end
      tick();
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_lock();
    test_violation();
    test_stuck();
    test_tolerance();
    test_saturation();
    test_clr_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_monitor.md
Name: toggle_monitor

Overview:
- Receive-side checker for a free-running toggle waveform, i.e. a signal that alternates level every HALF_PERIOD clocks.
- Samples the waveform synchronously, measures the interval between edges and declares lock after a run of correct intervals.
- Reports period violations and stuck-at conditions, and counts errors.
- Sits on the consumer side of the toggle source as a synthesizable liveness/period monitor.

Parameters:
- HALF_PERIOD, 2: expected clocks between consecutive edges of din (>=2).
- TOL, 0: allowed ± deviation in clocks on each interval (TOL < HALF_PERIOD).
- LOCK_COUNT, 4: consecutive good intervals needed to declare lock (>=1).
- CNT_W, 8: width of err_cnt and edge_cnt.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: monitor enable. When low, the FSM is forced to IDLE; counters hold.
- din, in, 1: monitored toggle signal, already synchronous to clk.
- clr, in, 1: synchronous clear of err_cnt, edge_cnt and stuck.
- locked, out, 1: high while the FSM is in LOCKED.
- stuck, out, 1: sticky; set when no edge is seen for longer than the maximum interval.
- err_pulse, out, 1: one-cycle pulse per counted error.
- err_cnt, out, CNT_W: saturating error count.
- edge_cnt, out, CNT_W: wrapping count of detected edges while en=1.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; din_q=0; run_cnt=0; good_cnt=0.
- Edge detect:
  - din_q <= din every clock.
  - edge = en & (din != din_q).
  - The edge is evaluated at the same clock din_q captures the new level.
- Run counter:
  - On edge, run_cnt <= 0.
  - Otherwise run_cnt increments, saturating at 2*HALF_PERIOD+TOL+1.
  - Measured interval at an edge = run_cnt+1.
  - Good interval: HALF_PERIOD-TOL <= interval <= HALF_PERIOD+TOL.
- FSM states: IDLE, ACQUIRE, TRACK, LOCKED.
  - IDLE: on en=1 go to ACQUIRE; run_cnt=0, good_cnt=0.
  - ACQUIRE: first edge starts measurement and moves to TRACK. No interval is checked, because the previous edge time is unknown.
  - TRACK, good edge: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - TRACK, bad edge: good_cnt <= 0 and stay in TRACK. No error is counted before lock.
  - LOCKED, good edge: stay in LOCKED.
  - LOCKED, bad edge: err_pulse=1, err_cnt++, good_cnt=0, go to TRACK.
  - en=0 in any state: go to IDLE next clock, good_cnt=0. stuck, err_cnt and edge_cnt are retained.
- Stuck detection (states TRACK/LOCKED):
  - Condition: run_cnt reaches 2*HALF_PERIOD+TOL with no edge.
  - Effect: stuck <= 1, go to ACQUIRE, good_cnt=0.
  - If the state was LOCKED, also err_pulse=1 and err_cnt++.
  - Fires once per stuck episode. Re-arm happens only after the next edge via ACQUIRE.
  - stuck stays high until clr or reset.
- Output timing:
  - locked rises on the clock that registers the LOCK_COUNT-th good edge.
  - err_pulse is registered and is high exactly one cycle after the offending clock.
- Counters:
  - err_cnt saturates at 2^CNT_W-1.
  - edge_cnt wraps modulo 2^CNT_W.
- Simultaneous events:
  - clr and a new error in the same cycle: clr wins for stuck and edge_cnt; err_cnt loads 1, and err_pulse still asserts.
  - Edge on the same clock run_cnt would hit the stuck threshold: the edge wins and is evaluated as an interval.
- Asynchronous reset mid-operation returns everything to reset values immediately. The first cycle after release is IDLE.

Test Plan:
- Lock acquisition. Defaults, en=1, din toggles every 2 clks → locked=1 on the clock of the 5th edge (1 acquire + 4 good); err_cnt=0; edge_cnt=5 at that point.
- Period violation. While locked, one half-period stretched to 3 clks → err_pulse for 1 cycle, err_cnt=1, locked=0. Relock after 4 further good intervals.
- Stuck-at. While locked, hold din constant → stuck=1 and err_pulse once at run_cnt=4 (5 clks after the last edge); err_cnt +1 only; state ACQUIRE. Resuming toggling relocks after 5 edges; stuck stays 1 until clr.
- Tolerance. TOL=1, HALF_PERIOD=4, intervals 3,5,4,5 → all good, locked after LOCK_COUNT good edges; interval 6 → error.
- Saturation, clear and enable. CNT_W=2, force 5 locked errors → err_cnt=3. Pulse clr → err_cnt=0, stuck=0, edge_cnt=0. en=0 for 10 clks while din toggles → edge_cnt unchanged, locked=0.
- Async reset. Assert rst_n=0 mid-interval while locked → all outputs 0 immediately. After release, relock requires full acquisition.
